// File: rtl/alarm_key_pkg.sv
// Shared types and 50 MHz timing defaults for the alarm-setting key path.
// Pure declarations; no logic, no latency, no flow control.
package alarm_key_pkg;

    localparam int CLK_FREQ_HZ           = 50_000_000;
    localparam int KEY_HOLD_CYCLES_DEF   = 25_000_000;  // 0.5 s to first repeat
    localparam int KEY_REPEAT_CYCLES_DEF = 10_000_000;  // 0.2 s between repeats
    localparam int KEY_CNT_W_DEF         = 25;

    typedef enum logic [1:0] {
        LOCK   = 2'd0,
        IDLE   = 2'd1,
        PRESS  = 2'd2,
        REPEAT = 2'd3
    } key_state_t;

endpackage

// File: rtl/key_timer.sv
// Loadable up-counter with synchronous clear, enable and terminal-count compare.
// tc is combinational from the count; count updates one cycle after en/ld/cnt_clr.
// No backpressure; the owner decides when to clear at terminal count.
module key_timer #(
    parameter int CNT_W = 25
) (
    input  logic             cclk,
    input  logic             clr,
    input  logic             cnt_clr,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_dat,
    input  logic             en,
    input  logic [CNT_W-1:0] term_dat,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge cclk) begin
        if (clr || cnt_clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_dat;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == term_dat);

endmodule

// File: rtl/alarm_key_event.sv
// Turns the debounced alarm key level into press and auto-repeat pulses (ALARM_KEY_REPEAT_EN enables repeat).
// All outputs registered: press_p one cycle after the rising key sample.
// No backpressure; pulses are single-cycle and fire-and-forget.
module alarm_key_event
    import alarm_key_pkg::*;
#(
    parameter int HOLD_CYCLES   = KEY_HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES_DEF,
    parameter int CNT_W         = KEY_CNT_W_DEF
) (
    input  logic cclk,
    input  logic clr,
    input  logic key_in,
    input  logic alarm_d,
    output logic press_p,
    output logic rpt_p,
    output logic hold
);

    key_state_t state;
    key_state_t state_nxt;
    logic       key_q;
    logic       key_rise;
    logic       press_nxt;

    assign key_rise = key_in & ~key_q;

    always_ff @(posedge cclk) begin
        if (clr) begin
            state   <= LOCK;
            key_q   <= 1'b0;
            press_p <= 1'b0;
        end else begin
            state   <= state_nxt;
            key_q   <= key_in;
            press_p <= press_nxt;
        end
    end

`ifdef ALARM_KEY_REPEAT_EN
    logic             tc;
    logic             tmr_act;
    logic             tmr_clr;
    logic             tmr_en;
    logic             rpt_nxt;
    logic [CNT_W-1:0] term_dat;

    // One timer serves both intervals; the compare value follows the state.
    assign term_dat = (state == PRESS) ? CNT_W'(HOLD_CYCLES - 1)
                                       : CNT_W'(REPEAT_CYCLES - 1);

    key_timer #(
        .CNT_W (CNT_W)
    ) u_key_timer (
        .cclk     (cclk),
        .clr      (clr),
        .cnt_clr  (tmr_clr),
        .ld       (1'b0),
        .ld_dat   ('0),
        .en       (tmr_en),
        .term_dat (term_dat),
        .tc       (tc)
    );

    always_ff @(posedge cclk) begin
        if (clr) begin
            rpt_p <= 1'b0;
            hold  <= 1'b0;
        end else begin
            rpt_p <= rpt_nxt;
            hold  <= (state_nxt == REPEAT);
        end
    end
`else
    logic [CNT_W-1:0] unused_cfg;

    assign unused_cfg = CNT_W'(HOLD_CYCLES) ^ CNT_W'(REPEAT_CYCLES);
    assign rpt_p      = 1'b0;
    assign hold       = 1'b0;
`endif

    // Mode exit overrides every state; a key still down parks in LOCK.
    always_comb begin
        state_nxt = state;
        if (!alarm_d) begin
            state_nxt = key_in ? LOCK : IDLE;
        end else begin
            case (state)
                LOCK:    if (!key_in)  state_nxt = IDLE;
                IDLE:    if (key_rise) state_nxt = PRESS;
`ifdef ALARM_KEY_REPEAT_EN
                PRESS: begin
                    if (!key_in)  state_nxt = IDLE;
                    else if (tc)  state_nxt = REPEAT;
                end
`else
                PRESS:   if (!key_in)  state_nxt = IDLE;
`endif
                REPEAT:  if (!key_in)  state_nxt = IDLE;
                default: state_nxt = LOCK;
            endcase
        end
    end

    always_comb begin
        press_nxt = alarm_d && (state == IDLE) && key_rise;
`ifdef ALARM_KEY_REPEAT_EN
        // Release takes priority over terminal count: tmr_act drops with key_in.
        tmr_act = alarm_d && key_in && ((state == PRESS) || (state == REPEAT));
        rpt_nxt = tmr_act && tc;
        tmr_clr = !tmr_act || tc;
        tmr_en  = tmr_act && !tc;
`endif
    end

endmodule

// File: doc/alarm_key_event.md
# alarm_key_event

Converts the debounced alarm-setting button level into discrete edit events for the alarm-time registers: one pulse per press, then auto-repeat pulses while the button is held. It sits directly downstream of the alarm-mode button debouncer and upstream of the alarm hour/minute increment logic. It is the consumer end of the debounced-button interface. Events are generated only while the clock is in alarm mode.

## Interface
- `HOLD_CYCLES`, 25_000_000: cycles from the press pulse to the first repeat pulse (0.5 s at 50 MHz); must be ≥ 2.
- `REPEAT_CYCLES`, 10_000_000: cycles between successive repeat pulses (0.2 s at 50 MHz); must be ≥ 2.
- `CNT_W`, 25: counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, REPEAT_CYCLES).
- `cclk` input, 1 bit: 50 MHz system clock. Single clock domain.
- `clr` input, 1 bit: reset. Synchronous, active-high.
- `key_in` input, 1 bit: debounced button level; 1 = pressed. Synchronous to `cclk`.
- `alarm_d` input, 1 bit: mode index; 0 = clock mode, 1 = alarm clock mode.
- `press_p` output, 1 bit: one-cycle pulse on each accepted press.
- `rpt_p` output, 1 bit: one-cycle pulse for each auto-repeat.
- `hold` output, 1 bit: level; 1 while in the REPEAT state.

## Operation
- State machine with four states:
  - LOCK: wait for the button to be released.
  - IDLE: wait for a press.
  - PRESS: held, counting toward the first repeat.
  - REPEAT: auto-repeating.
- `key_q` is a registered copy of `key_in`. A rising edge is `key_in & ~key_q`.
- Transitions are evaluated in this priority order (highest first):
  1. `clr` = 1: go to LOCK. Counter = 0, `key_q` = 0, all outputs 0.
  2. `alarm_d` = 0: go to LOCK if `key_in` = 1, else IDLE. Counter = 0, no pulses.
  3. LOCK: go to IDLE when `key_in` = 0. No pulses.
  4. IDLE: on a rising edge, assert `press_p`, go to PRESS, counter = 0.
  5. PRESS or REPEAT with `key_in` = 0: go to IDLE, counter = 0, no pulse. Release beats terminal count in the same cycle.
  6. PRESS: increment the counter. When counter = HOLD_CYCLES−1, assert `rpt_p`, go to REPEAT, counter = 0.
  7. REPEAT: increment the counter. When counter = REPEAT_CYCLES−1, assert `rpt_p`, counter = 0.
- Because reset goes to LOCK, a button held through reset or through a mode entry never produces an event. It must be released and pressed again.
- A press while `alarm_d` = 0 is ignored entirely.
- The counter never wraps. It is always cleared at terminal count.
- `press_p` and `rpt_p` are never high in the same cycle.

## Timing
- All outputs are registered. Reset value of `press_p`, `rpt_p` and `hold` is 0.
- `press_p` rises one cycle after the edge at which `key_in` is first sampled high in IDLE with `alarm_d` = 1.
- First `rpt_p` comes exactly HOLD_CYCLES cycles after `press_p`.
- Each later `rpt_p` comes exactly REPEAT_CYCLES cycles after the previous one.
- `hold` rises in the same cycle as the first `rpt_p`. It falls one cycle after `key_in` or `alarm_d` is sampled low.
- Minimum press-to-press spacing: a release lasting one cycle in IDLE is enough to re-arm.

## Configuration
- Macro: `ALARM_KEY_REPEAT_EN`.
- Defined: full behaviour as described above.
- Undefined:
  - PRESS never times out; it stays in PRESS until release or mode exit.
  - REPEAT state and counter logic are removed.
  - `rpt_p` and `hold` are tied to 0.
  - `press_p` behaviour and timing are unchanged.

## Structure
- Shared package `alarm_key_pkg`:
  - state enum `key_state_t` (LOCK, IDLE, PRESS, REPEAT);
  - default constants `KEY_HOLD_CYCLES_DEF` and `KEY_REPEAT_CYCLES_DEF`, alongside the clock's other 50 MHz timing constants.
- One sub-module, `key_timer`:
  - loadable up-counter with synchronous clear, enable and terminal-count compare;
  - it is used for both the hold interval and the repeat interval.
- The FSM and output registers stay in the top module.

## Test plan
All scenarios use HOLD_CYCLES = 8 and REPEAT_CYCLES = 4.
- Tap: `alarm_d` = 1, `key_in` high for 3 cycles then low → exactly one `press_p`, one cycle after the rise. No `rpt_p`. `hold` stays 0.
- Long hold: `key_in` high for 30 cycles → `press_p` at t+1, `rpt_p` at t+9, t+13, t+17, t+21, t+25, t+29. `hold` is 1 from t+9 until one cycle after release.
- Release at terminal count: `key_in` drops in the cycle the counter reaches 7 → no `rpt_p`, state IDLE, `hold` stays 0.
- Mode gating: press while `alarm_d` = 0 → no pulses. Raise `alarm_d` with the key held → still no pulse. Release, then press again → one `press_p`.
- Reset mid-repeat: assert `clr` for 1 cycle while in REPEAT with the key held → outputs 0 the next cycle. No events until the key is released and re-pressed.
- Build without `ALARM_KEY_REPEAT_EN`: 30-cycle hold → single `press_p`. `rpt_p` and `hold` stay 0 throughout.
